// File: rtl/row_pack.sv
// row_pack: gathers ROWS reference rows, one per accepted beat, into a packed
// ROWS x ROW_PIX pixel block for the block-matching SAD array.
// One block is held in assembly while the previous one sits in the output
// register, so the row fetch can run one block ahead of the consumer.
module row_pack #(
    parameter int PIXEL   = 8,
    parameter int ROW_PIX = 32,
    parameter int ROWS    = 8,
    localparam int W      = ROW_PIX * PIXEL,
    localparam int BW     = ROWS * W,
    localparam int CW     = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [W-1:0]  row_in,
    input  logic          row_in_valid,
    output logic          row_in_ready,
    output logic [BW-1:0] ref_ou,
    output logic          ou_valid,
    input  logic          ou_ready,
    output logic [CW-1:0] row_cnt
);

    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

    logic [BW-1:0] asm_q, asm_d;
    logic [BW-1:0] ref_q, ref_d;
    logic          ou_valid_q, ou_valid_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic          full_s;
    logic          accept_s;
    logic          xfer_s;

    // Handshake decode: ready only with a free slot and no flush; a full
    // buffer moves to the output once the output register is free or draining.
    always_comb begin
        full_s       = (row_cnt_q == ROWS_C);
        row_in_ready = !full_s && !flush;
        accept_s     = row_in_valid && row_in_ready;
        xfer_s       = full_s && !flush && (!ou_valid_q || ou_ready);
    end

    // Assembly buffer: place the accepted row into slot row_cnt, first row in the MSBs.
    always_comb begin
        asm_d = asm_q;
        if (accept_s) begin
            for (int k = 0; k < ROWS; k++) begin
                if (row_cnt_q == CW'(k)) begin
                    asm_d[(ROWS-k)*W-1 -: W] = row_in;
                end else begin
                    asm_d[(ROWS-k)*W-1 -: W] = asm_q[(ROWS-k)*W-1 -: W];
                end
            end
        end else begin
            asm_d = asm_q;
        end
    end

    // Row counter: flush wins, then transfer, then a counted accept.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (flush) begin
            row_cnt_d = '0;
        end else if (xfer_s) begin
            row_cnt_d = '0;
        end else if (accept_s) begin
            row_cnt_d = row_cnt_q + CW'(1);
        end else begin
            row_cnt_d = row_cnt_q;
        end
    end

    // Output register: load on transfer, drop valid on a plain drain, else hold.
    always_comb begin
        ref_d      = ref_q;
        ou_valid_d = ou_valid_q;
        if (xfer_s) begin
            ref_d      = asm_q;
            ou_valid_d = 1'b1;
        end else if (ou_valid_q && ou_ready) begin
            ref_d      = ref_q;
            ou_valid_d = 1'b0;
        end else begin
            ref_d      = ref_q;
            ou_valid_d = ou_valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q      <= '0;
            ref_q      <= '0;
            ou_valid_q <= 1'b0;
            row_cnt_q  <= '0;
        end else begin
            asm_q      <= asm_d;
            ref_q      <= ref_d;
            ou_valid_q <= ou_valid_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    assign ref_ou   = ref_q;
    assign ou_valid = ou_valid_q;
    assign row_cnt  = row_cnt_q;

endmodule

// File: tb/tb_row_pack.sv
// Testbench for row_pack: directed scenarios plus a long randomized run.
// A queue-based reference model predicts handshakes and completed blocks;
// a separate monitor pops expected blocks whenever the DUT hands one over.
module tb_row_pack;

    localparam int W  = 256;
    localparam int BW = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  row_in = '0;
    logic          row_in_valid = 1'b0;
    logic          row_in_ready;
    logic [BW-1:0] ref_ou;
    logic          ou_valid;
    logic          ou_ready = 1'b0;
    logic [3:0]    row_cnt;

    row_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .row_in       (row_in),
        .row_in_valid (row_in_valid),
        .row_in_ready (row_in_ready),
        .ref_ou       (ref_ou),
        .ou_valid     (ou_valid),
        .ou_ready     (ou_ready),
        .row_cnt      (row_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0]  asm_m[$];
    logic [BW-1:0] exp_q[$];
    bit            occ_m;
    int            acc_cnt;
    int            xfer_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;
    bit            prev_hold = 1'b0;
    logic [BW-1:0] prev_ref;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < 8; k++) begin
                if (act[(8-k)*W-1 -: W] !== exp[(8-k)*W-1 -: W]) begin
                    $display("FAIL %s: row %0d got %h expected %h (t=%0t)", nm, k,
                             act[(8-k)*W-1 -: W], exp[(8-k)*W-1 -: W], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [W-1:0] fill_row(input logic [7:0] b);
        return {32{b}};
    endfunction

    // One clock cycle: drive inputs, check observable state, advance the model.
    task automatic cycle(input bit v, input logic [W-1:0] r, input bit f, input bit rdy);
        bit exp_rdy, full, xfer, drain;
        logic [BW-1:0] blk;
        @(negedge clk);
        row_in_valid = v;
        row_in       = r;
        flush        = f;
        ou_ready     = rdy;
        #1;
        exp_rdy = (asm_m.size() != 8) && !f;
        chk("row_in_ready", int'(row_in_ready), int'(exp_rdy));
        chk("row_cnt", int'(row_cnt), asm_m.size());
        chk("ou_valid", int'(ou_valid), int'(occ_m));
        full  = (asm_m.size() == 8);
        xfer  = !f && full && (!occ_m || rdy);
        drain = occ_m && rdy && !xfer;
        if (f) begin
            asm_m.delete();
        end else if (xfer) begin
            blk = '0;
            foreach (asm_m[k]) blk = {blk[BW-W-1:0], asm_m[k]};
            exp_q.push_back(blk);
            asm_m.delete();
            occ_m = 1'b1;
            xfer_cnt++;
        end else if (v && exp_rdy) begin
            asm_m.push_back(r);
            acc_cnt++;
        end
        if (drain) occ_m = 1'b0;
    endtask

    task automatic model_clear();
        asm_m.delete();
        exp_q.delete();
        occ_m     = 1'b0;
        prev_hold = 1'b0;
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear at once.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #3;
        mon_en = 1'b0;
        row_in_valid = 1'b0;
        flush = 1'b0;
        ou_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({nm, "_ou_valid"}, int'(ou_valid), 0);
        chk({nm, "_row_cnt"}, int'(row_cnt), 0);
        chk_blk({nm, "_ref_ou"}, ref_ou, '0);
        model_clear();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: on each output handshake compare against the next expected block,
    // and check ref_ou held still while the consumer stalls.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (prev_hold) chk_blk("ref_ou_stable", ref_ou, prev_ref);
                if (ou_valid && ou_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", 1, 0);
                    end else begin
                        chk_blk("block", ref_ou, exp_q.pop_front());
                    end
                end
                prev_hold = ou_valid && !ou_ready;
                prev_ref  = ref_ou;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        logic [BW-1:0] alt_blk;
        int budget;
        model_clear();
        acc_cnt  = 0;
        xfer_cnt = 0;

        // Reset state
        #2;
        chk("rst_row_cnt", int'(row_cnt), 0);
        chk("rst_ou_valid", int'(ou_valid), 0);
        chk("rst_ready", int'(row_in_ready), 1);
        chk_blk("rst_ref_ou", ref_ou, '0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // T1: rows k = {32{k}}, latency and slot placement
        for (int k = 1; k <= 8; k++) cycle(1'b1, fill_row(8'(k)), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t1_valid_before", int'(ou_valid), 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t1_valid_after", int'(ou_valid), 1);
        chk_blk("t1_top_row", {ref_ou[2047:1792], 1792'b0}, {fill_row(8'h01), 1792'b0});
        chk_blk("t1_bot_row", {1792'b0, ref_ou[255:0]}, {1792'b0, fill_row(8'h08)});
        cycle(1'b0, '0, 1'b0, 1'b1);

        // T2: alternating all-ones / all-zeros rows
        for (int k = 0; k < 8; k++)
            cycle(1'b1, (k % 2 == 0) ? fill_row(8'hFF) : fill_row(8'h00), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        alt_blk = {4{fill_row(8'hFF), fill_row(8'h00)}};
        chk_blk("t2_alt", ref_ou, alt_blk);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // T3: 16 rows under full backpressure
        acc_cnt = 0;
        budget  = 0;
        while (acc_cnt < 16 && budget < 40) begin
            cycle(1'b1, rand_row(), 1'b0, 1'b0);
            budget++;
        end
        chk("t3_accepted", acc_cnt, 16);
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        chk("t3_row_cnt_full", int'(row_cnt), 8);
        chk("t3_ready_low", int'(row_in_ready), 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t3_row_cnt_after", int'(row_cnt), 0);
        chk("t3_valid_after", int'(ou_valid), 1);
        if (exp_q.size() != 0) chk_blk("t3_block2", ref_ou, exp_q[0]);
        else chk("t3_exp_empty", 0, 1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // T4: partial block flushed together with a valid row
        for (int k = 0; k < 5; k++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b1, rand_row(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t4_row_cnt_flushed", int'(row_cnt), 0);
        for (int k = 0; k < 8; k++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // T5: reset with row_cnt=3 and a pending output block
        for (int k = 0; k < 8; k++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t5_pre_row_cnt", int'(row_cnt), 3);
        chk("t5_pre_valid", int'(ou_valid), 1);
        async_reset("t5");

        // T6: random traffic over 1000 transferred blocks
        xfer_cnt = 0;
        budget   = 0;
        while (xfer_cnt < 1000 && budget < 60000) begin
            cycle($urandom_range(0, 3) != 0, rand_row(), $urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1);
            budget++;
        end
        chk("t6_blocks", xfer_cnt >= 1000 ? 1 : 0, 1);
        budget = 0;
        while ((exp_q.size() != 0 || occ_m) && budget < 20) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            budget++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t6_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
